// File: rtl/clksel_pkg.sv
// ---------------------------------------------------------------------------
// clksel_pkg
// Shared definitions for the CPU clock-domain sequencer:
//   - clk_state_e : FSM state encodings (LS_RUN, GAP, HS_RUN, WAIT_LS)
//   - DIV_W       : width of the HS divider select
//   - HALF_W      : width of the HS half-period counter (max half = 8 cycles)
//   - TO_W        : width of the optional WAIT_LS watchdog counter
//   - half_last() : terminal count of the half-period counter for a divider
// ---------------------------------------------------------------------------
package clksel_pkg;

  localparam int DIV_W  = 2;
  localparam int HALF_W = 3;
  localparam int TO_W   = 8;
  localparam int SPAN_W = HALF_W + 1;

  typedef enum logic [2:0] {
    LS_RUN  = 3'd0,
    GAP     = 3'd1,
    HS_RUN  = 3'd2,
    WAIT_LS = 3'd3
  } clk_state_e;

  // Last count value of a half period lasting 2^div hsclk cycles.
  function automatic logic [HALF_W-1:0] half_last(input logic [DIV_W-1:0] div);
    logic [SPAN_W-1:0] span;
    span = SPAN_W'(1) << div;
    return HALF_W'(span - SPAN_W'(1));
  endfunction

endpackage

// File: rtl/clksel_sequencer_if.sv
// ---------------------------------------------------------------------------
// clksel_sequencer_if
// Groups the clock-request inputs and the clock/status outputs of the
// sequencer.
//   lsclk_in        : BBC phi2-phase level, asynchronous to hsclk
//   hsclk_sel       : 1 = run CPU on hsclk, 0 = run on lsclk
//   cpuclk_div_sel  : HS half period = 2^div hsclk cycles
//   cpu_ck_phi2     : registered CPU phi2 clock
//   hsclk_selected  : CPU is running from hsclk
//   lsclk_selected  : CPU is running from lsclk
//   timeout_pulse   : one-cycle pulse on a forced WAIT_LS exit
// master: the side that issues requests and observes status.
// slave : the sequencer itself.
// ---------------------------------------------------------------------------
interface clksel_sequencer_if;
  import clksel_pkg::*;

  logic             lsclk_in;
  logic             hsclk_sel;
  logic [DIV_W-1:0] cpuclk_div_sel;
  logic             cpu_ck_phi2;
  logic             hsclk_selected;
  logic             lsclk_selected;
  logic             timeout_pulse;

  modport master (
    output lsclk_in,
    output hsclk_sel,
    output cpuclk_div_sel,
    input  cpu_ck_phi2,
    input  hsclk_selected,
    input  lsclk_selected,
    input  timeout_pulse
  );

  modport slave (
    input  lsclk_in,
    input  hsclk_sel,
    input  cpuclk_div_sel,
    output cpu_ck_phi2,
    output hsclk_selected,
    output lsclk_selected,
    output timeout_pulse
  );

endinterface

// File: rtl/clksel_sync.sv
// ---------------------------------------------------------------------------
// clksel_sync
// Multi-flop synchroniser for the asynchronous lsclk level plus a falling
// edge detector on the synchronised level. lsclk is treated purely as data.
// Ports:
//   clk      in  sampling clock (hsclk)
//   rst      in  asynchronous active-high reset, clears every stage
//   async_in in  asynchronous level to synchronise
//   level    out synchronised level (last synchroniser stage)
//   fall     out one-cycle pulse when the synchronised level goes 1 -> 0
// Parameter SYNC_STAGES: number of synchroniser flops (minimum 2).
// ---------------------------------------------------------------------------
module clksel_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Shift the raw level into the chain; remember last synchronised value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clksel_sequencer.sv
// ---------------------------------------------------------------------------
// clksel_sequencer
// Shares the single CPU phi2 output between the BBC 2MHz phase (lsclk) and a
// divided hsclk, switching glitch-free at phase boundaries. Everything runs
// in the hsclk domain; lsclk is sampled through clksel_sync.
// Ports:
//   hsclk  in   sole clock, rising edge
//   rst    in   asynchronous active-high reset
//   bus    slave modport of clksel_sequencer_if (requests, phi2, status)
// Parameters:
//   SYNC_STAGES  lsclk synchroniser depth (min 2)
//   GAP_CYCLES   cycles phi2 is held low between LS stop and HS start (min 1)
//   TIMEOUT_CYC  WAIT_LS watchdog limit (used only with CLKSEL_TIMEOUT_EN)
// Configuration macro CLKSEL_TIMEOUT_EN: when defined, an 8-bit watchdog
// forces WAIT_LS back to LS_RUN after TIMEOUT_CYC cycles without an lsclk
// fall and pulses timeout_pulse; when undefined WAIT_LS waits indefinitely
// and timeout_pulse stays 0.
// ---------------------------------------------------------------------------
module clksel_sequencer
  import clksel_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                hsclk,
  input logic                rst,
  clksel_sequencer_if.slave  bus
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  if ((SYNC_STAGES < 2) || (GAP_CYCLES < 1) || (TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 256)) begin : g_param_check
    $error("clksel_sequencer: parameter out of range");
  end

  clk_state_e        state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              phi2_q, phi2_d;
  logic              hs_sel_q, hs_sel_d;
  logic              ls_sel_q, ls_sel_d;
  logic              pulse_q, pulse_d;
  logic              ls_s;
  logic              ls_fall;

`ifdef CLKSEL_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0]   wd_cnt_q, wd_cnt_d;
`endif

  clksel_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (hsclk),
    .rst      (rst),
    .async_in (bus.lsclk_in),
    .level    (ls_s),
    .fall     (ls_fall)
  );

  // Next-state, phi2 and counter logic of the clock-switch FSM.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    half_cnt_d = half_cnt_q;
    div_d      = div_q;
    phi2_d     = phi2_q;
    pulse_d    = 1'b0;
`ifdef CLKSEL_TIMEOUT_EN
    // Watchdog only accumulates while waiting; any other state clears it.
    wd_cnt_d   = {TO_W{1'b0}};
`endif

    case (state_q)
      LS_RUN: begin
        // phi2 mirrors the BBC phase; a switch may only start at its fall,
        // where phi2 is already low.
        phi2_d    = ls_s;
        gap_cnt_d = {GAP_W{1'b0}};
        if (bus.hsclk_sel && ls_fall) begin
          state_d = GAP;
        end else begin
          state_d = LS_RUN;
        end
      end

      GAP: begin
        phi2_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          // HS always starts with a full low (phi1) half period.
          state_d    = HS_RUN;
          gap_cnt_d  = {GAP_W{1'b0}};
          half_cnt_d = {HALF_W{1'b0}};
          div_d      = bus.cpuclk_div_sel;
        end else begin
          gap_cnt_d  = gap_cnt_q + GAP_W'(1);
        end
      end

      HS_RUN: begin
        if (half_cnt_q == half_last(div_q)) begin
          // Half-period boundary: the only point where the divider is taken
          // and the only point where HS may be left (after a high phase).
          half_cnt_d = {HALF_W{1'b0}};
          div_d      = bus.cpuclk_div_sel;
          if (phi2_q && !bus.hsclk_sel) begin
            state_d = WAIT_LS;
            phi2_d  = 1'b0;
          end else begin
            phi2_d  = ~phi2_q;
          end
        end else begin
          half_cnt_d = half_cnt_q + HALF_W'(1);
        end
      end

      WAIT_LS: begin
        // CPU phi1 is stretched until the BBC phi1 begins; new requests are
        // ignored until LS_RUN is reached.
        phi2_d = 1'b0;
        if (ls_fall) begin
          state_d = LS_RUN;
        end
`ifdef CLKSEL_TIMEOUT_EN
        else if (wd_cnt_q == TO_LAST) begin
          state_d = LS_RUN;
          pulse_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + TO_W'(1);
        end
`else
        else begin
          state_d = WAIT_LS;
        end
`endif
      end

      default: begin
        state_d    = LS_RUN;
        phi2_d     = 1'b0;
        gap_cnt_d  = {GAP_W{1'b0}};
        half_cnt_d = {HALF_W{1'b0}};
      end
    endcase

    // Status flags follow the state the FSM is entering, so they line up
    // with the registered state.
    hs_sel_d = (state_d == HS_RUN);
    ls_sel_d = (state_d == LS_RUN);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      state_q    <= LS_RUN;
      gap_cnt_q  <= {GAP_W{1'b0}};
      half_cnt_q <= {HALF_W{1'b0}};
      div_q      <= {DIV_W{1'b0}};
      phi2_q     <= 1'b0;
      hs_sel_q   <= 1'b0;
      ls_sel_q   <= 1'b1;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      half_cnt_q <= half_cnt_d;
      div_q      <= div_d;
      phi2_q     <= phi2_d;
      hs_sel_q   <= hs_sel_d;
      ls_sel_q   <= ls_sel_d;
      pulse_q    <= pulse_d;
    end
  end

`ifdef CLKSEL_TIMEOUT_EN
  // WAIT_LS watchdog counter.
  always_ff @(posedge hsclk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= {TO_W{1'b0}};
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign bus.cpu_ck_phi2    = phi2_q;
  assign bus.hsclk_selected = hs_sel_q;
  assign bus.lsclk_selected = ls_sel_q;
  assign bus.timeout_pulse  = pulse_q;

endmodule

// File: tb/tb_clksel_sequencer.sv
module tb_clksel_sequencer;
  import clksel_pkg::*;

  localparam int SYNC = 2;
  localparam int GAPC = 2;
  localparam int TOC  = 64;

  localparam int MODE_LS   = 0;
  localparam int MODE_GAP  = 1;
  localparam int MODE_HS   = 2;
  localparam int MODE_WAIT = 3;

  logic hsclk = 1'b0;
  logic rst   = 1'b1;
  bit   ls_run   = 1'b0;
  bit   ls_force = 1'b0;
  int   ls_cnt   = 0;

  int total = 0;
  int bad   = 0;

  // Behavioural model: expected outputs for the current cycle.
  int   m_mode  = MODE_LS;
  int   m_left  = 0;   // cycles left in current GAP / HS half, including this one
  int   m_wait  = 0;   // cycles already spent waiting for the BBC phase
  logic m_level = 1'b0;
  logic m_phi2  = 1'b0;
  logic m_pulse = 1'b0;
  logic m_prev  = 1'b0;
  logic m_pipe [SYNC];

  clksel_sequencer_if bus ();

  clksel_sequencer #(
    .SYNC_STAGES (SYNC),
    .GAP_CYCLES  (GAPC),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .hsclk (hsclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 hsclk = ~hsclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_LS; m_left = 0; m_wait = 0; m_level = 1'b0;
    m_phi2 = 1'b0; m_pulse = 1'b0; m_prev = 1'b0;
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
  endtask

  // One hsclk edge: from the pre-edge picture, decide what the next cycle shows.
  task automatic model_step();
    logic ls_now;
    logic fall;
    ls_now  = m_pipe[SYNC-1];
    fall    = m_prev & ~ls_now;
    m_pulse = 1'b0;
    case (m_mode)
      MODE_LS: begin
        m_phi2 = ls_now;
        if (bus.hsclk_sel && fall) begin m_mode = MODE_GAP; m_left = GAPC; end
      end
      MODE_GAP: begin
        m_phi2 = 1'b0;
        if (m_left == 1) begin
          m_mode = MODE_HS; m_level = 1'b0;
          m_left = 1 << int'(bus.cpuclk_div_sel);
        end else m_left = m_left - 1;
      end
      MODE_HS: begin
        if (m_left > 1) m_left = m_left - 1;
        else if (m_level && !bus.hsclk_sel) begin
          m_mode = MODE_WAIT; m_wait = 0;
        end else begin
          m_level = ~m_level;
          m_left  = 1 << int'(bus.cpuclk_div_sel);
        end
        m_phi2 = (m_mode == MODE_HS) ? m_level : 1'b0;
      end
      default: begin
        m_phi2 = 1'b0;
        if (fall) m_mode = MODE_LS;
`ifdef CLKSEL_TIMEOUT_EN
        else if (m_wait == TOC - 1) begin m_mode = MODE_LS; m_pulse = 1'b1; end
        else m_wait = m_wait + 1;
`endif
      end
    endcase
    m_prev = ls_now;
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = bus.lsclk_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge hsclk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Every cycle: DUT outputs against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge hsclk);
      check("phi2",   {31'd0, bus.cpu_ck_phi2},    {31'd0, m_phi2});
      check("hs_sel", {31'd0, bus.hsclk_selected}, {31'd0, m_mode == MODE_HS});
      check("ls_sel", {31'd0, bus.lsclk_selected}, {31'd0, m_mode == MODE_LS});
      check("pulse",  {31'd0, bus.timeout_pulse},  {31'd0, m_pulse});
    end
  end

  // BBC phase generator: 4 hsclk high / 4 low, or a forced level.
  initial begin
    bus.lsclk_in = 1'b0;
    forever begin
      @(negedge hsclk);
      if (ls_run) begin
        if (ls_cnt == 3) begin bus.lsclk_in = ~bus.lsclk_in; ls_cnt = 0; end
        else ls_cnt++;
      end else begin
        bus.lsclk_in = ls_force; ls_cnt = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge hsclk);
    #1;
  endtask

  function automatic logic probe(input int which);
    case (which)
      0: return bus.cpu_ck_phi2;
      1: return bus.hsclk_selected;
      2: return bus.lsclk_selected;
      default: return bus.timeout_pulse;
    endcase
  endfunction

  // Bounded wait for an output to reach a level; expiry is a failed check.
  task automatic wait_for(input int which, input logic want, input int budget, input string name);
    int n;
    n = 0;
    while (probe(which) !== want && n < budget) begin cyc(); n++; end
    check(name, {31'd0, probe(which)}, {31'd0, want});
  endtask

  initial begin
    logic [7:0]  pat8;
    logic [19:0] pat20;
    logic [9:0]  pat10;
    int n;
    int pulses;
    int pulse_at;

    bus.hsclk_sel      = 1'b0;
    bus.cpuclk_div_sel = 2'd1;
    rst = 1'b1;
    repeat (3) cyc();
    check("reset_phi2",   {31'd0, bus.cpu_ck_phi2},    32'd0);
    check("reset_ls_sel", {31'd0, bus.lsclk_selected}, 32'd1);
    check("reset_hs_sel", {31'd0, bus.hsclk_selected}, 32'd0);
    rst = 1'b0;
    repeat (4) cyc();

    // LS tracking latency: SYNC_STAGES+1 edges from lsclk_in to phi2.
    ls_force = 1'b1;
    cyc(); cyc();
    check("lat_2_edges", {31'd0, bus.cpu_ck_phi2}, 32'd0);
    cyc();
    check("lat_3_edges", {31'd0, bus.cpu_ck_phi2}, 32'd1);
    ls_run = 1'b1;
    repeat (40) cyc();
    check("ls_idle_sel", {31'd0, bus.lsclk_selected}, 32'd1);

    // Request while BBC phase is high: gap of 2, then div=1 HS clock.
    wait_for(0, 1'b1, 20, "t2_phi2_high");
    bus.hsclk_sel = 1'b1;
    wait_for(0, 1'b0, 20, "t2_phi2_fall");
    n = 0;
    while (bus.hsclk_selected !== 1'b1 && n < 20) begin n++; cyc(); end
    check("t2_gap_len", n, 32'd2);
    for (int i = 0; i < 8; i++) begin pat8 = {pat8[6:0], bus.cpu_ck_phi2}; cyc(); end
    check("t2_div1_pattern", {24'd0, pat8}, {24'd0, 8'b0011_0011});

    // Divider 1 -> 3 at the start of a high half, then 3 -> 0 mid half.
    wait_for(0, 1'b0, 10, "t4_low");
    wait_for(0, 1'b1, 10, "t4_high");
    bus.cpuclk_div_sel = 2'd3;
    for (int i = 0; i < 20; i++) begin pat20 = {pat20[18:0], bus.cpu_ck_phi2}; cyc(); end
    check("t4_div1to3", {12'd0, pat20}, {12'd0, 20'b11_00000000_11111111_00});
    bus.cpuclk_div_sel = 2'd0;
    for (int i = 0; i < 10; i++) begin pat10 = {pat10[8:0], bus.cpu_ck_phi2}; cyc(); end
    check("t4_div3to0", {22'd0, pat10}, {22'd0, 10'b0000001010});

    // Drop request on a high phase: WAIT_LS, re-request ignored until LS_RUN.
    wait_for(0, 1'b1, 10, "t3_high");
    bus.hsclk_sel = 1'b0;
    cyc();
    check("t3_wait_phi2", {31'd0, bus.cpu_ck_phi2},    32'd0);
    check("t3_wait_hs",   {31'd0, bus.hsclk_selected}, 32'd0);
    check("t3_wait_ls",   {31'd0, bus.lsclk_selected}, 32'd0);
    bus.hsclk_sel = 1'b1;
    wait_for(2, 1'b1, 24, "t3_back_to_ls");
    check("t3_ls_phi2", {31'd0, bus.cpu_ck_phi2}, 32'd0);

    // Reset in the middle of GAP.
    wait_for(2, 1'b0, 24, "t5_enter_gap");
    check("t5_gap_hs", {31'd0, bus.hsclk_selected}, 32'd0);
    rst = 1'b1;
    #1;
    check("t5_rst_phi2", {31'd0, bus.cpu_ck_phi2},    32'd0);
    check("t5_rst_ls",   {31'd0, bus.lsclk_selected}, 32'd1);
    check("t5_rst_hs",   {31'd0, bus.hsclk_selected}, 32'd0);
    bus.hsclk_sel = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check("t5_after_ls", {31'd0, bus.lsclk_selected}, 32'd1);
    repeat (20) cyc();

    // BBC phase stuck low while waiting to return to LS.
    bus.cpuclk_div_sel = 2'd0;
    bus.hsclk_sel = 1'b1;
    wait_for(1, 1'b1, 40, "t6_hs");
    ls_force = 1'b0;
    ls_run   = 1'b0;
    repeat (12) cyc();
    wait_for(0, 1'b1, 10, "t6_high");
    bus.hsclk_sel = 1'b0;
    pulses = 0;
    pulse_at = 0;
    for (int i = 1; i <= 80; i++) begin
      cyc();
      if (bus.timeout_pulse === 1'b1) begin pulses++; pulse_at = i; end
    end
`ifdef CLKSEL_TIMEOUT_EN
    check("t6_pulse_count", pulses, 32'd1);
    check("t6_pulse_at", pulse_at, TOC + 1);
    check("t6_ls_sel", {31'd0, bus.lsclk_selected}, 32'd1);
`else
    check("t6_pulse_count", pulses, 32'd0);
    check("t6_ls_sel", {31'd0, bus.lsclk_selected}, 32'd0);
    check("t6_hs_sel", {31'd0, bus.hsclk_selected}, 32'd0);
`endif
    ls_run = 1'b1;
    repeat (30) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
